// File: rtl/alu_serial_arbiter_if.sv
// Request/response bundle between two requesters and the serial ALU arbiter.
// The arbiter side uses the slave modport, requesters/consumers use master.
interface alu_serial_arbiter_if;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_a;
  logic [1:0][31:0] req_b;
  logic [1:0][2:0]  req_op;
  logic [1:0][3:0]  req_crc4;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [1:0]       rsp_status;
  logic [31:0]      rsp_c;
  logic [3:0]       rsp_flags;
  logic [2:0]       rsp_crc3;
  logic [5:0]       rsp_err_flags;
  logic             rsp_parity;

  modport master (
    output req_valid, req_a, req_b, req_op, req_crc4, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_status, rsp_c, rsp_flags,
           rsp_crc3, rsp_err_flags, rsp_parity
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_crc4, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_status, rsp_c, rsp_flags,
           rsp_crc3, rsp_err_flags, rsp_parity
  );
endinterface

// File: rtl/alu_serial_arbiter.sv
// Two-requester round-robin arbiter that serialises commands to a bit-serial
// ALU over sin and deserialises its response from sout, with a response timeout.
module alu_serial_arbiter #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_serial_arbiter_if.slave bus,
  output logic                sin,
  input  logic                sout,
  output logic                busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERROR   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} state_t;
  state_t state;

  logic          last_grant;
  logic          owner;
  logic          win_id;
  logic          any_valid;
  logic [1:0]    ready_vec;
  logic [31:0]   win_a;
  logic [31:0]   win_b;
  logic [2:0]    win_op;
  logic [3:0]    win_crc4;
  logic [98:0]   frame;
  logic [97:0]   tx_shift;
  logic [6:0]    tx_cnt;
  logic [TW-1:0] timer;
  logic          in_pkt;
  logic [3:0]    rx_bit;
  logic [8:0]    rx_shift;
  logic [2:0]    rx_pkts;
  logic [31:0]   rx_c;

  assign any_valid = |bus.req_valid;
  assign win_id    = bus.req_valid[~last_grant] ? ~last_grant : last_grant;
  assign win_a     = bus.req_a[win_id];
  assign win_b     = bus.req_b[win_id];
  assign win_op    = bus.req_op[win_id];
  assign win_crc4  = bus.req_crc4[win_id];
  assign busy      = (state != IDLE);

  // Ready is combinational so the winner is accepted in the IDLE cycle itself.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = rst_n && (state == IDLE) && any_valid && (win_id == 1'(gi));
    end
    for (gi = 0; gi < 4; gi++) begin : g_frame
      assign frame[98-11*gi -: 11] = {2'b00, win_b[31-8*gi -: 8], 1'b1};
      assign frame[54-11*gi -: 11] = {2'b00, win_a[31-8*gi -: 8], 1'b1};
    end
  endgenerate
  assign frame[10:0]   = {2'b01, 1'b0, win_op, win_crc4, 1'b1};
  assign bus.req_ready = ready_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      last_grant        <= 1'b1;
      owner             <= 1'b0;
      sin               <= 1'b1;
      tx_shift          <= '0;
      tx_cnt            <= '0;
      timer             <= '0;
      in_pkt            <= 1'b0;
      rx_bit            <= '0;
      rx_shift          <= '0;
      rx_pkts           <= '0;
      rx_c              <= '0;
      bus.rsp_valid     <= 1'b0;
      bus.rsp_id        <= 1'b0;
      bus.rsp_status    <= ST_OK;
      bus.rsp_c         <= '0;
      bus.rsp_flags     <= '0;
      bus.rsp_crc3      <= '0;
      bus.rsp_err_flags <= '0;
      bus.rsp_parity    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            last_grant <= win_id;
            owner      <= win_id;
            sin        <= frame[98];
            tx_shift   <= frame[97:0];
            tx_cnt     <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tx_cnt == 7'd98) begin
            sin     <= 1'b1;
            timer   <= '0;
            in_pkt  <= 1'b0;
            rx_pkts <= '0;
            rx_c    <= '0;
            state   <= WAIT;
          end else begin
            sin      <= tx_shift[97];
            tx_shift <= {tx_shift[96:0], 1'b1};
            tx_cnt   <= tx_cnt + 7'd1;
          end
        end
        // WAIT is the gap before the first packet; RECV gaps share the same timer rule.
        WAIT, RECV: begin
          if (!in_pkt) begin
            if (!sout) begin
              in_pkt <= 1'b1;
              rx_bit <= 4'd1;
              timer  <= '0;
              state  <= RECV;
            end else if (timer == TIMER_LAST) begin
              state             <= RESP;
              bus.rsp_valid     <= 1'b1;
              bus.rsp_id        <= owner;
              bus.rsp_status    <= ST_TIMEOUT;
              bus.rsp_c         <= '0;
              bus.rsp_flags     <= '0;
              bus.rsp_crc3      <= '0;
              bus.rsp_err_flags <= '0;
              bus.rsp_parity    <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end else if (rx_bit != 4'd10) begin
            rx_shift <= {rx_shift[7:0], sout};
            rx_bit   <= rx_bit + 4'd1;
          end else begin
            in_pkt <= 1'b0;
            timer  <= '0;
            if (rx_shift[8] || rx_pkts == 3'd4) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_id    <= owner;
              if (rx_shift[8] && rx_pkts == 3'd4) begin
                bus.rsp_status    <= ST_OK;
                bus.rsp_c         <= rx_c;
                bus.rsp_flags     <= rx_shift[6:3];
                bus.rsp_crc3      <= rx_shift[2:0];
                bus.rsp_err_flags <= '0;
                bus.rsp_parity    <= 1'b0;
              end else begin
                // Control packet out of sequence, or a fifth data packet.
                bus.rsp_status    <= ST_ERROR;
                bus.rsp_c         <= '0;
                bus.rsp_flags     <= '0;
                bus.rsp_crc3      <= '0;
                bus.rsp_err_flags <= rx_shift[8] ? rx_shift[6:1] : 6'd0;
                bus.rsp_parity    <= rx_shift[8] ? rx_shift[0] : 1'b0;
              end
            end else begin
              rx_c    <= {rx_c[23:0], rx_shift[7:0]};
              rx_pkts <= rx_pkts + 3'd1;
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_arbiter.sv
// Scoreboard bench: stimulus queues expected frames/responses, a serial ALU
// model answers on sout, and a monitor checks each accepted response.
module tb_alu_serial_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic sin;
  logic sout;
  logic busy;

  always #5 clk = ~clk;

  alu_serial_arbiter_if bus();

  alu_serial_arbiter #(.TIMEOUT_CYCLES(1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .sin   (sin),
    .sout  (sout),
    .busy  (busy)
  );

  typedef struct {
    logic        id;
    logic [1:0]  status;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc3;
    logic [5:0]  err;
    logic        par;
  } rsp_t;

  // kind: 0 OK response, 1 single ctl packet, 2 silence, 3 two data packets then silence
  typedef struct {
    int          kind;
    logic [31:0] c;
    logic [3:0]  flags;
    logic [2:0]  crc3;
    logic [7:0]  epay;
    int          gap;
  } alu_t;

  rsp_t         exp_q[$];
  alu_t         alu_q[$];
  logic [98:0]  frame_q[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           last_bit_cyc = 0;
  int           rsp_first_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic rsp_t mk_rsp(input logic id, input logic [1:0] st, input logic [31:0] c,
                                  input logic [3:0] fl, input logic [2:0] crc3,
                                  input logic [5:0] err, input logic par);
    rsp_t r;
    r.id = id; r.status = st; r.c = c; r.flags = fl; r.crc3 = crc3; r.err = err; r.par = par;
    return r;
  endfunction

  function automatic alu_t mk_alu(input int kind, input logic [31:0] c, input logic [3:0] fl,
                                  input logic [2:0] crc3, input logic [7:0] epay, input int gap);
    alu_t s;
    s.kind = kind; s.c = c; s.flags = fl; s.crc3 = crc3; s.epay = epay; s.gap = gap;
    return s;
  endfunction

  // 9 packets of {start 0, type, payload MSB first, stop 1}: B bytes, A bytes, ctl.
  function automatic logic [98:0] build_frame(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] op, input logic [3:0] crc);
    logic [98:0] f;
    logic [7:0]  by;
    f = '0;
    for (int p = 0; p < 9; p++) begin
      if (p < 4)      by = b[31-8*p -: 8];
      else if (p < 8) by = a[31-8*(p-4) -: 8];
      else            by = {1'b0, op, crc};
      f[98-11*p -: 11] = {1'b0, (p == 8), by, 1'b1};
    end
    return f;
  endfunction

  function automatic logic [48:0] rsp_fields();
    return {bus.rsp_id, bus.rsp_status, bus.rsp_c, bus.rsp_flags, bus.rsp_crc3,
            bus.rsp_err_flags, bus.rsp_parity};
  endfunction

  task automatic send_pkt(input logic typ, input logic [7:0] pl);
    logic [10:0] p;
    p = {1'b0, typ, pl, 1'b1};
    for (int i = 10; i >= 0; i--) begin
      @(posedge clk);
      #1 sout = p[i];
    end
  endtask

  task automatic alu_respond(input alu_t s);
    logic [31:0] cc;
    cc = s.c;
    repeat (s.gap) @(posedge clk);
    case (s.kind)
      0: begin
        for (int i = 0; i < 4; i++) begin
          send_pkt(1'b0, cc[31-8*i -: 8]);
          repeat (s.gap) @(posedge clk);
        end
        send_pkt(1'b1, {1'b0, s.flags, s.crc3});
      end
      1: send_pkt(1'b1, s.epay);
      3: begin
        send_pkt(1'b0, cc[31:24]);
        repeat (s.gap) @(posedge clk);
        send_pkt(1'b0, cc[23:16]);
      end
      default: ;
    endcase
  endtask

  // Serial ALU model: capture a full command frame, check it, play the script.
  initial begin : alu_model
    logic [98:0] rx;
    bit          ok;
    alu_t        s;
    sout = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && sin === 1'b0) begin
        rx     = '0;
        rx[98] = 1'b0;
        ok     = 1'b1;
        for (int i = 1; i < 99; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            ok = 1'b0;
            break;
          end
          rx[98-i] = sin;
        end
        if (ok) begin
          last_bit_cyc = cyc;
          if (frame_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_unexpected: got %0h, expected no frame", rx);
          end else begin
            chk("sin_frame", rx, frame_q.pop_front());
          end
          if (alu_q.size() != 0) begin
            s = alu_q.pop_front();
            alu_respond(s);
          end
        end
      end
    end
  end

  // Response monitor: a handshake happens at the posedge after valid&&ready is seen here.
  initial begin : monitor
    rsp_t        e;
    logic [48:0] snap;
    bit          in_rsp;
    bit          stable;
    int          stall_cnt;
    in_rsp = 1'b0;
    stable = 1'b1;
    stall_cnt = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid) begin
        if (!in_rsp) begin
          in_rsp        = 1'b1;
          rsp_first_cyc = cyc;
          snap          = rsp_fields();
          stable        = 1'b1;
          stall_cnt     = 0;
        end else if (rsp_fields() !== snap || bus.req_ready !== 2'b00) begin
          stable = 1'b0;
        end
        if (bus.rsp_ready) begin
          in_rsp = 1'b0;
          $display("[TB] rsp id=%0d status=%0d c=%08h flags=%0h crc3=%0h err=%02h par=%0d stall=%0d",
                   bus.rsp_id, bus.rsp_status, bus.rsp_c, bus.rsp_flags, bus.rsp_crc3,
                   bus.rsp_err_flags, bus.rsp_parity, stall_cnt);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: got id %0d status %0d, expected no response",
                     bus.rsp_id, bus.rsp_status);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_id", bus.rsp_id, e.id);
            chk("rsp_status", bus.rsp_status, e.status);
            chk("rsp_c", bus.rsp_c, e.c);
            chk("rsp_flags_crc3", {bus.rsp_flags, bus.rsp_crc3}, {e.flags, e.crc3});
            chk("rsp_err_parity", {bus.rsp_err_flags, bus.rsp_parity}, {e.err, e.par});
          end
          if (stall_cnt > 0) chk("rsp_stall_stable", stable, 1'b1);
        end else begin
          stall_cnt++;
        end
      end else begin
        in_rsp = 1'b0;
      end
    end
  end

  task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, input logic [3:0] crc, input bit track,
                       input alu_t s, input rsp_t e);
    logic [1:0] oh;
    int n;
    if (track) begin
      frame_q.push_back(build_frame(a, b, op, crc));
      alu_q.push_back(s);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_a[id]     = a;
    bus.req_b[id]     = b;
    bus.req_op[id]    = op;
    bus.req_crc4[id]  = crc;
    bus.req_valid[id] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.req_ready[id] && n < 300);
    oh = 2'b00;
    oh[id] = 1'b1;
    chk("req_ready", bus.req_ready, oh);
    @(posedge clk);
    #1 bus.req_valid[id] = 1'b0;
    @(negedge clk);
    chk("req_ready_pulse", bus.req_ready, 2'b00);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_wait", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 50000 cycles");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    alu_t        s_none;
    rsp_t        e_none;
    logic [1:0]  exp_oh [4];
    logic [1:0]  prev;
    int          g;
    int          n;
    bit          seen;
    bit          sin_bad;

    s_none = mk_alu(2, 32'h0, 4'h0, 3'h0, 8'h00, 0);
    e_none = mk_rsp(1'b0, 2'b00, 32'h0, 4'h0, 3'h0, 6'h0, 1'b0);

    rst_n         = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_crc4  = '0;
    bus.rsp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_sin", sin, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_rsp_valid", bus.rsp_valid, 1'b0);
    chk("reset_req_ready", bus.req_ready, 2'b00);
    chk("reset_rsp_fields", rsp_fields(), 49'h0);
    bus.req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ADD 3+5: ALU answers C=8, flags 0, crc3 2.
    issue(0, 32'h0000_0003, 32'h0000_0005, 3'b100, 4'hA, 1'b1,
          mk_alu(0, 32'h0000_0008, 4'h0, 3'b010, 8'h00, 2),
          mk_rsp(1'b0, 2'b00, 32'h0000_0008, 4'h0, 3'd2, 6'h0, 1'b0));
    wait_done(600);

    // Control packet 0x93 first: err_flags 001001, parity 1.
    issue(1, 32'h1234_0000, 32'h0000_4321, 3'b000, 4'h3, 1'b1,
          mk_alu(1, 32'h0, 4'h0, 3'h0, 8'h93, 3),
          mk_rsp(1'b1, 2'b01, 32'h0, 4'h0, 3'h0, 6'b001001, 1'b1));
    wait_done(600);

    // OK response with 7 idle cycles between every packet.
    issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 4'h6, 1'b1,
          mk_alu(0, 32'h1234_5678, 4'b1010, 3'b101, 8'h00, 7),
          mk_rsp(1'b0, 2'b00, 32'h1234_5678, 4'hA, 3'd5, 6'h0, 1'b0));
    wait_done(800);

    // Response held for 20 cycles while requester 0 asks for service.
    bus.rsp_ready = 1'b0;
    issue(1, 32'h0000_00FF, 32'h0000_0F0F, 3'b001, 4'hC, 1'b1,
          mk_alu(0, 32'hDEAD_BEEF, 4'h3, 3'h7, 8'h00, 1),
          mk_rsp(1'b1, 2'b00, 32'hDEAD_BEEF, 4'h3, 3'h7, 6'h0, 1'b0));
    n = 0;
    while (!bus.rsp_valid && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("stall_rsp_valid_seen", bus.rsp_valid, 1'b1);
    @(posedge clk);
    #1 bus.req_valid[0] = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    bus.rsp_ready    = 1'b1;
    bus.req_valid[0] = 1'b0;
    wait_done(100);

    // Silent ALU: 1000 idle cycles after the last stop bit, then TIMEOUT.
    issue(0, 32'h0, 32'h0, 3'b000, 4'h0, 1'b1, s_none,
          mk_rsp(1'b0, 2'b10, 32'h0, 4'h0, 3'h0, 6'h0, 1'b0));
    wait_done(1500);
    chk("timeout_idle_cycles", rsp_first_cyc - last_bit_cyc - 1, 1000);

    // Two data packets then silence: the inter-packet gap times out too.
    issue(1, 32'h0000_0001, 32'h0000_0002, 3'b001, 4'h3, 1'b1,
          mk_alu(3, 32'hAABB_0000, 4'h0, 3'h0, 8'h00, 2),
          mk_rsp(1'b1, 2'b10, 32'h0, 4'h0, 3'h0, 6'h0, 1'b0));
    wait_done(1600);

    // Reset around cycle 40 of SEND aborts without a response.
    issue(0, 32'h0000_1111, 32'h0000_2222, 3'b100, 4'h5, 1'b0, s_none, e_none);
    repeat (39) @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("abort_sin", sin, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_rsp_valid", bus.rsp_valid, 1'b0);
    chk("abort_req_ready", bus.req_ready, 2'b00);
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    rst_n = 1'b1;
    seen = 1'b0;
    sin_bad = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
      if (!sin) sin_bad = 1'b1;
    end
    chk("abort_no_rsp", seen, 1'b0);
    chk("abort_sin_idle", sin_bad, 1'b0);

    // Both requesters held valid: grants alternate 0,1,0,1 starting fresh after reset.
    bus.req_a[0] = 32'h1020_3040; bus.req_b[0] = 32'h5060_7080;
    bus.req_op[0] = 3'b000;       bus.req_crc4[0] = 4'h1;
    bus.req_a[1] = 32'hCAFE_F00D; bus.req_b[1] = 32'h0BAD_BEEF;
    bus.req_op[1] = 3'b001;       bus.req_crc4[1] = 4'hE;
    for (int k = 0; k < 2; k++) begin
      frame_q.push_back(build_frame(32'h1020_3040, 32'h5060_7080, 3'b000, 4'h1));
      frame_q.push_back(build_frame(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'b001, 4'hE));
    end
    alu_q.push_back(mk_alu(0, 32'hA5A5_A5A5, 4'hF, 3'h1, 8'h00, 1));
    alu_q.push_back(mk_alu(1, 32'h0, 4'h0, 3'h0, 8'h7E, 1));
    alu_q.push_back(mk_alu(0, 32'h0000_0001, 4'h0, 3'h0, 8'h00, 0));
    alu_q.push_back(mk_alu(1, 32'h0, 4'h0, 3'h0, 8'h01, 4));
    exp_q.push_back(mk_rsp(1'b0, 2'b00, 32'hA5A5_A5A5, 4'hF, 3'h1, 6'h0, 1'b0));
    exp_q.push_back(mk_rsp(1'b1, 2'b01, 32'h0, 4'h0, 3'h0, 6'b111111, 1'b0));
    exp_q.push_back(mk_rsp(1'b0, 2'b00, 32'h0000_0001, 4'h0, 3'h0, 6'h0, 1'b0));
    exp_q.push_back(mk_rsp(1'b1, 2'b01, 32'h0, 4'h0, 3'h0, 6'b000000, 1'b1));
    exp_oh[0] = 2'b01;
    exp_oh[1] = 2'b10;
    exp_oh[2] = 2'b01;
    exp_oh[3] = 2'b10;
    @(posedge clk);
    #1 bus.req_valid = 2'b11;
    g = 0;
    prev = 2'b00;
    for (int cy = 0; cy < 2500 && g < 4; cy++) begin
      @(negedge clk);
      if (prev != 2'b00) chk("rr_pulse", bus.req_ready, 2'b00);
      prev = bus.req_ready;
      if (bus.req_ready != 2'b00) begin
        chk("rr_grant", bus.req_ready, exp_oh[g]);
        g++;
      end
    end
    chk("rr_grant_count", g, 4);
    @(posedge clk);
    #1 bus.req_valid = 2'b00;
    @(negedge clk);
    chk("rr_pulse", bus.req_ready, 2'b00);
    wait_done(800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
